ingr_rr_arbiter: RTL and testbench

INGR_RR_ARBITER -- requirements
Module: ingr_rr_arbiter

---
 rtl/ingr_rr_arbiter.sv | 159 +++++++++++++++
 tb/tb_ingr_rr_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ingr_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ingr_rr_arbiter
//  Description : Packet-locked round-robin arbiter merging NUM_PORTS AXI4-Stream
//                ingress ports onto one egress stream. A port is chosen in IDLE
//                (one-cycle arbitration) and keeps the output until its tlast
//                beat is accepted. The egress path is a pure combinational mux,
//                so there is no buffering.
//  Options     : `define INGR_ARB_PKT_COUNT_EN adds the per-port 32-bit
//                completed-packet counters on output pkt_count.
//  Revision    : 1.0 - initial release
// ============================================================================
module ingr_rr_arbiter #(
   parameter int AXIS_BUS_WIDTH = 64,
   parameter int NUM_PORTS      = 4,
   parameter int PORT_ID_WIDTH  = 2
) (
   input  logic                                    aclk,
   input  logic                                    aresetn,
   input  logic [NUM_PORTS*AXIS_BUS_WIDTH-1:0]     axis_in_tdata,
   input  logic [NUM_PORTS*(AXIS_BUS_WIDTH/8)-1:0] axis_in_tkeep,
   input  logic [NUM_PORTS-1:0]                    axis_in_tlast,
   input  logic [NUM_PORTS-1:0]                    axis_in_tvalid,
   output logic [NUM_PORTS-1:0]                    axis_in_tready,
   output logic [AXIS_BUS_WIDTH-1:0]               axis_out_tdata,
   output logic [AXIS_BUS_WIDTH/8-1:0]             axis_out_tkeep,
   output logic [PORT_ID_WIDTH-1:0]                axis_out_tid,
   output logic                                    axis_out_tlast,
   output logic                                    axis_out_tvalid,
   input  logic                                    axis_out_tready
`ifdef INGR_ARB_PKT_COUNT_EN
   ,
   output logic [NUM_PORTS*32-1:0]                 pkt_count
`endif
);

   localparam int                     c_KEEP_W   = AXIS_BUS_WIDTH / 8;
   // Last grant resets to the highest port so that port 0 wins first.
   localparam logic [PORT_ID_WIDTH-1:0] c_LAST_RST = PORT_ID_WIDTH'(NUM_PORTS - 1);

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_LOCKED = 1'b1
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [PORT_ID_WIDTH-1:0]  r_grant;
   logic [PORT_ID_WIDTH-1:0]  r_last_grant;
   logic [PORT_ID_WIDTH-1:0]  w_arb_pick;
   int                        w_dist;
   int                        w_best;
   logic                      w_any_req;
   logic [AXIS_BUS_WIDTH-1:0] w_sel_data;
   logic [c_KEEP_W-1:0]       w_sel_keep;
   logic                      w_sel_last;
   logic                      w_sel_valid;
   logic                      w_fire;
   logic                      w_last_beat;

   assign w_any_req   = |axis_in_tvalid;
   assign w_fire      = (r_state == S_LOCKED) && w_sel_valid && axis_out_tready;
   assign w_last_beat = w_fire && w_sel_last;

   // Round-robin pick: requester with the smallest cyclic distance after last_grant.
   always_comb begin
      w_arb_pick = '0;
      w_best     = NUM_PORTS;
      w_dist     = 0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         w_dist = (p + NUM_PORTS - 1 - int'(r_last_grant)) % NUM_PORTS;
         if (axis_in_tvalid[p] && (w_dist < w_best)) begin
            w_best     = w_dist;
            w_arb_pick = PORT_ID_WIDTH'(p);
         end
      end
   end

   // Select the granted port's stream fields.
   always_comb begin
      w_sel_data  = '0;
      w_sel_keep  = '0;
      w_sel_last  = 1'b0;
      w_sel_valid = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (r_grant == PORT_ID_WIDTH'(p)) begin
            w_sel_data  = axis_in_tdata[p*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH];
            w_sel_keep  = axis_in_tkeep[p*c_KEEP_W +: c_KEEP_W];
            w_sel_last  = axis_in_tlast[p];
            w_sel_valid = axis_in_tvalid[p];
         end
      end
   end

   // Next-state logic: lock on any request, release after the accepted tlast beat.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_any_req)   w_state_nxt = S_LOCKED;
         S_LOCKED: if (w_last_beat) w_state_nxt = S_IDLE;
         default:                   w_state_nxt = S_IDLE;
      endcase
   end

   // Output drive: everything quiet in IDLE, granted port passed through when LOCKED.
   always_comb begin
      axis_in_tready  = '0;
      axis_out_tdata  = '0;
      axis_out_tkeep  = '0;
      axis_out_tid    = '0;
      axis_out_tlast  = 1'b0;
      axis_out_tvalid = 1'b0;
      if (r_state == S_LOCKED) begin
         axis_out_tdata  = w_sel_data;
         axis_out_tkeep  = w_sel_keep;
         axis_out_tid    = r_grant;
         axis_out_tlast  = w_sel_last;
         axis_out_tvalid = w_sel_valid;
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_grant == PORT_ID_WIDTH'(p)) axis_in_tready[p] = axis_out_tready;
         end
      end
   end

   // State register.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Grant captured at arbitration; last_grant updated when the packet closes.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_grant      <= '0;
         r_last_grant <= c_LAST_RST;
      end else begin
         if ((r_state == S_IDLE) && w_any_req) r_grant <= w_arb_pick;
         if (w_last_beat)                      r_last_grant <= r_grant;
      end
   end

`ifdef INGR_ARB_PKT_COUNT_EN
   generate
      for (genvar g = 0; g < NUM_PORTS; g++) begin : g_pkt_cnt
         logic [31:0] r_cnt;

         // Count accepted tlast beats of this port; wraps naturally at 2^32.
         always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn)                                            r_cnt <= '0;
            else if (w_last_beat && (r_grant == PORT_ID_WIDTH'(g)))  r_cnt <= r_cnt + 32'd1;
         end

         assign pkt_count[g*32 +: 32] = r_cnt;
      end
   endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_ingr_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ingr_rr_arbiter
//  Description : Scoreboard bench for ingr_rr_arbiter. Per-port packet queues
//                feed drivers; a packet-level reference arbiter pushes the
//                expected egress beats, and a monitor pops/compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ingr_rr_arbiter;

   localparam int W   = 64;
   localparam int K   = W / 8;
   localparam int N   = 4;
   localparam int IDW = 2;

   logic             aclk;
   logic             aresetn;
   logic [N*W-1:0]   axis_in_tdata;
   logic [N*K-1:0]   axis_in_tkeep;
   logic [N-1:0]     axis_in_tlast;
   logic [N-1:0]     axis_in_tvalid;
   logic [N-1:0]     axis_in_tready;
   logic [W-1:0]     axis_out_tdata;
   logic [K-1:0]     axis_out_tkeep;
   logic [IDW-1:0]   axis_out_tid;
   logic             axis_out_tlast;
   logic             axis_out_tvalid;
   logic             axis_out_tready;
`ifdef INGR_ARB_PKT_COUNT_EN
   logic [N*32-1:0]  pkt_count;
`endif

   ingr_rr_arbiter #(
      .AXIS_BUS_WIDTH (W),
      .NUM_PORTS      (N),
      .PORT_ID_WIDTH  (IDW)
   ) u_dut (
      .aclk            (aclk),
      .aresetn         (aresetn),
      .axis_in_tdata   (axis_in_tdata),
      .axis_in_tkeep   (axis_in_tkeep),
      .axis_in_tlast   (axis_in_tlast),
      .axis_in_tvalid  (axis_in_tvalid),
      .axis_in_tready  (axis_in_tready),
      .axis_out_tdata  (axis_out_tdata),
      .axis_out_tkeep  (axis_out_tkeep),
      .axis_out_tid    (axis_out_tid),
      .axis_out_tlast  (axis_out_tlast),
      .axis_out_tvalid (axis_out_tvalid),
      .axis_out_tready (axis_out_tready)
`ifdef INGR_ARB_PKT_COUNT_EN
      ,
      .pkt_count       (pkt_count)
`endif
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   typedef struct packed {
      logic [W-1:0] data;
      logic [K-1:0] keep;
      logic         last;
   } beat_t;

   typedef struct packed {
      logic [IDW-1:0] tid;
      logic [W-1:0]   data;
      logic [K-1:0]   keep;
      logic           last;
   } exp_t;

   beat_t        port_q[N][$];
   exp_t         exp_q[$];
   int           vectors = 0;
   int           errors  = 0;
   int           m_owner = -1;
   int           m_last  = N - 1;
   int           m_pick;
   int unsigned  m_pkts[N];
   logic [N-1:0] m_exp_rdy;
   logic [N-1:0] fire      = '0;
   logic [N-1:0] force_gap = '0;
   int           gap_pct   = 0;
   exp_t         m_e;
   exp_t         mon_e;
   logic         m_done;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      vectors++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // ---------------- reference arbiter (packet-level) ----------------
   initial begin
      for (int p = 0; p < N; p++) m_pkts[p] = 0;
      forever begin
         @(negedge aclk);
         if (!aresetn) begin
            m_owner = -1;
            m_last  = N - 1;
            exp_q.delete();
            fire    = '0;
            for (int p = 0; p < N; p++) m_pkts[p] = 0;
         end else begin
            m_exp_rdy = '0;
            if (m_owner >= 0 && axis_out_tready) m_exp_rdy[m_owner] = 1'b1;
            chk("in_tready", 64'(axis_in_tready), 64'(m_exp_rdy));
            chk("out_tvalid", 64'(axis_out_tvalid),
                64'((m_owner >= 0) ? axis_in_tvalid[m_owner] : 1'b0));
            if (m_owner >= 0) chk("out_tid", 64'(axis_out_tid), 64'(m_owner));
            fire = axis_in_tvalid & m_exp_rdy;
            if (m_owner < 0) begin
               if (axis_in_tvalid != '0) begin
                  m_pick = -1;
                  for (int d = 1; d <= N; d++)
                     if (m_pick < 0 && axis_in_tvalid[(m_last + d) % N]) m_pick = (m_last + d) % N;
                  m_owner = m_pick;
                  m_done  = 1'b0;
                  for (int i = 0; i < port_q[m_pick].size(); i++) begin
                     if (!m_done) begin
                        m_e.tid  = IDW'(m_pick);
                        m_e.data = port_q[m_pick][i].data;
                        m_e.keep = port_q[m_pick][i].keep;
                        m_e.last = port_q[m_pick][i].last;
                        exp_q.push_back(m_e);
                        m_done = port_q[m_pick][i].last;
                     end
                  end
               end
            end else if (axis_in_tvalid[m_owner] && axis_out_tready && axis_in_tlast[m_owner]) begin
               m_pkts[m_owner]++;
               m_last  = m_owner;
               m_owner = -1;
            end
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin
      forever begin
         @(negedge aclk);
         if (aresetn && axis_out_tvalid && axis_out_tready) begin
            if (exp_q.size() == 0) begin
               vectors++;
               errors++;
               $display("FAIL out_beat: got unexpected beat tid %0d data 0x%0h, expected none",
                        axis_out_tid, axis_out_tdata);
            end else begin
               mon_e = exp_q.pop_front();
               chk("beat_tid",  64'(axis_out_tid),   64'(mon_e.tid));
               chk("beat_data", axis_out_tdata,      mon_e.data);
               chk("beat_keep", 64'(axis_out_tkeep), 64'(mon_e.keep));
               chk("beat_last", 64'(axis_out_tlast), 64'(mon_e.last));
            end
         end
      end
   end

   // ---------------- ingress drivers ----------------
   initial begin
      axis_in_tvalid = '0;
      axis_in_tdata  = '0;
      axis_in_tkeep  = '0;
      axis_in_tlast  = '0;
      forever begin
         @(posedge aclk);
         for (int p = 0; p < N; p++) begin
            if (!aresetn)     port_q[p].delete();
            else if (fire[p]) port_q[p].delete(0);
         end
         #1;
         for (int p = 0; p < N; p++) begin
            if (aresetn && port_q[p].size() > 0 && !force_gap[p] &&
                $urandom_range(99) >= gap_pct) begin
               axis_in_tvalid[p]       = 1'b1;
               axis_in_tdata[p*W +: W] = port_q[p][0].data;
               axis_in_tkeep[p*K +: K] = port_q[p][0].keep;
               axis_in_tlast[p]        = port_q[p][0].last;
            end else begin
               axis_in_tvalid[p]       = 1'b0;
               axis_in_tdata[p*W +: W] = '0;
               axis_in_tkeep[p*K +: K] = '0;
               axis_in_tlast[p]        = 1'b0;
            end
         end
      end
   end

   task automatic push_pkt(input int port, input int len);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.data = {$urandom, $urandom};
         b.keep = K'($urandom_range(255));
         b.last = (i == len - 1);
         port_q[port].push_back(b);
      end
   endtask

   function automatic bit all_idle();
      bit r;
      r = (exp_q.size() == 0) && (m_owner < 0);
      for (int p = 0; p < N; p++) if (port_q[p].size() != 0) r = 0;
      return r;
   endfunction

   task automatic drain(input string name, output int cyc);
      cyc = 0;
      while (!all_idle() && cyc < 3000) begin
         @(posedge aclk);
         #2;
         cyc++;
      end
      if (!all_idle()) begin
         vectors++;
         errors++;
         $display("FAIL %s: traffic not drained after %0d cycles, expected drained", name, cyc);
      end
   endtask

   task automatic wait_size(input string name, input int port, input int sz);
      int c;
      c = 0;
      while (port_q[port].size() != sz && c < 200) begin
         @(posedge aclk);
         #2;
         c++;
      end
      if (port_q[port].size() != sz) begin
         vectors++;
         errors++;
         $display("FAIL %s: port %0d queue size %0d, expected %0d", name, port, port_q[port].size(), sz);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int cyc;
      int p;
      aresetn         = 1'b0;
      axis_out_tready = 1'b0;
      repeat (3) @(posedge aclk);
      #2;
      chk("rst_out_tvalid", 64'(axis_out_tvalid), 64'd0);
      chk("rst_in_tready",  64'(axis_in_tready),  64'd0);
      chk("rst_out_tid",    64'(axis_out_tid),    64'd0);
      @(posedge aclk);
      #1 aresetn = 1'b1;
      axis_out_tready = 1'b1;

      // All four ports with 2-beat packets: order 0,1,2,3,0 at 3 cycles each.
      @(posedge aclk);
      #2;
      push_pkt(0, 2); push_pkt(0, 2);
      push_pkt(1, 2); push_pkt(2, 2); push_pkt(3, 2);
      drain("rr_all", cyc);
      chk("rr_all_cycles", 64'(cyc), 64'd16);

      // Port 2 alone, three single-beat packets.
      push_pkt(2, 1); push_pkt(2, 1); push_pkt(2, 1);
      drain("solo_p2", cyc);
      chk("solo_p2_cycles", 64'(cyc), 64'd7);

      // Downstream stall mid-packet while another port requests.
      push_pkt(1, 4);
      wait_size("stall_start", 1, 3);
      axis_out_tready = 1'b0;
      push_pkt(3, 2);
      for (int i = 0; i < 5; i++) begin
         @(posedge aclk);
         #2;
         chk("stall_tid",    64'(axis_out_tid),    64'd1);
         chk("stall_tvalid", 64'(axis_out_tvalid), 64'd1);
      end
      axis_out_tready = 1'b1;
      drain("stall", cyc);

      // Granted port drops tvalid for 4 cycles mid-packet.
      push_pkt(0, 4);
      push_pkt(2, 2);
      wait_size("gap_start", 0, 3);
      force_gap[0] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge aclk);
         #2;
         chk("gap_tvalid", 64'(axis_out_tvalid), 64'd0);
         chk("gap_tid",    64'(axis_out_tid),    64'd0);
      end
      force_gap[0] = 1'b0;
      drain("gap", cyc);

      // Reset in the middle of a 4-beat packet.
      push_pkt(3, 4);
      wait_size("rst_mid_start", 3, 3);
      aresetn = 1'b0;
      #1;
      chk("rst_mid_tvalid", 64'(axis_out_tvalid), 64'd0);
      chk("rst_mid_tready", 64'(axis_in_tready),  64'd0);
      chk("rst_mid_tdata",  axis_out_tdata,       64'd0);
      repeat (2) @(posedge aclk);
      #1 aresetn = 1'b1;
      @(posedge aclk);
      #2;
      push_pkt(3, 2);
      push_pkt(0, 2);
      cyc = 0;
      while (!axis_out_tvalid && cyc < 20) begin
         @(posedge aclk);
         #2;
         cyc++;
      end
      chk("post_rst_first_tid",    64'(axis_out_tid),    64'd0);
      chk("post_rst_first_tvalid", 64'(axis_out_tvalid), 64'd1);
      drain("post_rst", cyc);

      // Counter traffic: ten packets on port 1, three on port 0.
      for (int i = 0; i < 10; i++) push_pkt(1, 1 + (i % 3));
      for (int i = 0; i < 3; i++)  push_pkt(0, 2);
      drain("count_traffic", cyc);

      // Randomised traffic with valid gaps and downstream backpressure.
      gap_pct = 25;
      for (int i = 0; i < 800; i++) begin
         @(posedge aclk);
         #2;
         axis_out_tready = ($urandom_range(99) < 70);
         if ($urandom_range(99) < 15) begin
            p = $urandom_range(N - 1);
            if (port_q[p].size() < 16) push_pkt(p, $urandom_range(1, 5));
         end
      end
      axis_out_tready = 1'b1;
      gap_pct = 0;
      drain("random", cyc);

`ifdef INGR_ARB_PKT_COUNT_EN
      for (int q = 0; q < N; q++)
         chk("pkt_count", 64'(pkt_count[q*32 +: 32]), 64'(m_pkts[q]));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end

endmodule
`default_nettype wire
